// File: rtl/psram_pkg.sv
// psram_pkg: types and constants shared by the PSRAM arbiter and the later
// muxes that sit in front of the PSRAM SPI bridge.
package psram_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_BUSY,
      ARB_DONE
   } arb_state_e;

   localparam int PSRAM_BLOCK_BYTES = 32;
   localparam int BLOCK_SHIFT       = $clog2(PSRAM_BLOCK_BYTES);
   localparam int PSRAM_ADDR_WIDTH  = 24;

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker.
//   req  : request vector, one bit per client
//   last : index served most recently; the search starts at last+1 mod N
//   gnt  : one-hot of the chosen client (zero when nothing requests)
//   idx  : binary index of the chosen client
//   any  : at least one request present
module rr_select #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   localparam int SW = IW + 1;   // holds last+k up to 2N-1 before the wrap

   logic [SW-1:0] sum;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, last} + SW'(k);
         if (sum >= SW'(N)) sum = sum - SW'(N);
         if (!any && req[sum[IW-1:0]]) begin
            any = 1'b1;
            idx = sum[IW-1:0];
         end
      end
      gnt[idx] = any;
   end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin mux between NUM_CLIENTS block requesters and
// the PSRAM SPI bridge.
//   clk, reset                 : system clock, async active-high reset
//   client_req/we/block_addr/
//   num_blocks/wdata           : per-client request (packed, client i at slice i)
//   client_grant/next_byte/
//   rvalid/done, client_rdata  : per-client handshake and shared read bus
//   start_pointer..data_in     : command and write data towards the bridge
//   data_out, undergoing_command,
//   send_me_next_byte          : status and read data from the bridge
module psram_arbiter
   import psram_pkg::*;
#(
   parameter int NUM_CLIENTS      = 4,
   parameter int BLOCK_ADDR_WIDTH = 16,
   parameter int RD_LAT           = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CLIENTS-1:0]            client_req,
   input  logic [NUM_CLIENTS-1:0]            client_we,
   input  logic [NUM_CLIENTS*BLOCK_ADDR_WIDTH-1:0] client_block_addr,
   input  logic [NUM_CLIENTS*5-1:0]          client_num_blocks,
   input  logic [NUM_CLIENTS*8-1:0]          client_wdata,
   output logic [NUM_CLIENTS-1:0]            client_grant,
   output logic [NUM_CLIENTS-1:0]            client_next_byte,
   output logic [7:0]                        client_rdata,
   output logic [NUM_CLIENTS-1:0]            client_rvalid,
   output logic [NUM_CLIENTS-1:0]            client_done,
   output logic [PSRAM_ADDR_WIDTH-1:0]       start_pointer,
   output logic [4:0]                        number_of_blocks,
   output logic                              output_enable,
   output logic                              write_enable,
   output logic [7:0]                        data_in,
   input  logic [7:0]                        data_out,
   input  logic                              undergoing_command,
   input  logic                              send_me_next_byte
);

   localparam int N   = NUM_CLIENTS;
   localparam int IW  = $clog2(N);
   localparam int BAW = BLOCK_ADDR_WIDTH;

   arb_state_e           state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d, last_q, last_d;
   logic                 we_q, we_d;
   logic [BAW-1:0]       addr_q, addr_d;
   logic [4:0]           blks_q, blks_d;
   logic [N-1:0]         grant_q, grant_d, done_q, done_d, rvalid_q, rvalid_d;
   logic [RD_LAT-1:0]    rd_pipe_q, rd_pipe_d;
   logic [7:0]           rdata_q, rdata_d;

   logic [N-1:0]         sel_gnt;
   logic [IW-1:0]        sel_idx;
   logic                 sel_any;
   logic                 rd_stb, active, en_gate;

   rr_select #(.N(N), .IW(IW)) u_rr (
      .req  (client_req),
      .last (last_q),
      .gnt  (sel_gnt),
      .idx  (sel_idx),
      .any  (sel_any)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      blks_d   = blks_q;
      grant_d  = grant_q;
      done_d   = '0;
      rvalid_d = '0;
      rdata_d  = rdata_q;

      // Read strobes enter a delay line matching the bridge read latency;
      // the tap at the end tags data_out for the current client.
      rd_stb    = (state_q == ARB_BUSY) && !we_q && send_me_next_byte;
      rd_pipe_d = (rd_pipe_q << 1) | RD_LAT'(rd_stb);
      if (rd_pipe_q[RD_LAT-1]) begin
         rvalid_d[idx_q] = 1'b1;
         rdata_d         = data_out;
      end

      unique case (state_q)
         ARB_IDLE: begin
            // done_q blocks for a cycle so the finishing client can drop req;
            // a non-empty pipe still needs idx_q for its remaining rvalids.
            if (sel_any && !done_q[idx_q] && (rd_pipe_q == '0)) begin
               idx_d   = sel_idx;
               last_d  = sel_idx;
               we_d    = client_we[sel_idx];
               addr_d  = client_block_addr[sel_idx*BAW +: BAW];
               blks_d  = client_num_blocks[sel_idx*5 +: 5];
               grant_d = sel_gnt;
               state_d = (client_num_blocks[sel_idx*5 +: 5] == 5'd0) ? ARB_DONE : ARB_ISSUE;
            end
         end
         ARB_ISSUE: if (undergoing_command)  state_d = ARB_BUSY;
         ARB_BUSY:  if (!undergoing_command) state_d = ARB_DONE;
         ARB_DONE: begin
            done_d[idx_q] = 1'b1;
            grant_d       = '0;
            state_d       = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         idx_q     <= '0;
         last_q    <= IW'(N-1);
         we_q      <= 1'b0;
         addr_q    <= '0;
         blks_q    <= '0;
         grant_q   <= '0;
         done_q    <= '0;
         rvalid_q  <= '0;
         rd_pipe_q <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         blks_q    <= blks_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         rvalid_q  <= rvalid_d;
         rd_pipe_q <= rd_pipe_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      active  = (state_q == ARB_ISSUE) || (state_q == ARB_BUSY);
      // In BUSY the enables follow undergoing_command so they are already
      // low in the cycle the bridge goes idle and cannot restart it.
      en_gate = (state_q == ARB_ISSUE) || ((state_q == ARB_BUSY) && undergoing_command);

      write_enable     = en_gate && we_q;
      output_enable    = en_gate && !we_q;
      start_pointer    = active ? PSRAM_ADDR_WIDTH'({addr_q, {BLOCK_SHIFT{1'b0}}}) : '0;
      number_of_blocks = active ? blks_q : 5'd0;
      data_in          = (active && we_q) ? client_wdata[idx_q*8 +: 8] : 8'd0;

      client_next_byte = '0;
      if ((state_q == ARB_BUSY) && we_q && send_me_next_byte)
         client_next_byte[idx_q] = 1'b1;

      client_grant  = grant_q;
      client_done   = done_q;
      client_rvalid = rvalid_q;
      client_rdata  = rdata_q;
   end

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed checks of psram_arbiter against a hand-driven
// bridge; inputs change just after negedge, outputs sampled before posedge.
module tb_psram_arbiter;

   localparam int N = 4, BAW = 16, RD_LAT = 8;

   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]     client_req = '0, client_we = '0;
   logic [N*BAW-1:0] client_block_addr = '0;
   logic [N*5-1:0]   client_num_blocks = '0;
   logic [N*8-1:0]   client_wdata;
   logic [N-1:0]     client_grant, client_next_byte, client_rvalid, client_done;
   logic [7:0]       client_rdata, data_in, data_out;
   logic [23:0]      start_pointer;
   logic [4:0]       number_of_blocks;
   logic             output_enable, write_enable;
   logic             undergoing_command = 1'b0, send_me_next_byte = 1'b0;

   // free-running cycle count doubles as the bridge read data
   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;
   assign data_out = cnt[7:0];

   // client 0 write source: advances on the edge after each next_byte pulse
   logic [7:0] wbyte = 8'h00;
   always @(posedge clk) if (client_next_byte[0]) wbyte <= wbyte + 8'd1;
   assign client_wdata = {8'hA3, 8'hA2, 8'hA1, wbyte};

   psram_arbiter #(.NUM_CLIENTS(N), .BLOCK_ADDR_WIDTH(BAW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset),
      .client_req(client_req), .client_we(client_we),
      .client_block_addr(client_block_addr), .client_num_blocks(client_num_blocks),
      .client_wdata(client_wdata), .client_grant(client_grant),
      .client_next_byte(client_next_byte), .client_rdata(client_rdata),
      .client_rvalid(client_rvalid), .client_done(client_done),
      .start_pointer(start_pointer), .number_of_blocks(number_of_blocks),
      .output_enable(output_enable), .write_enable(write_enable),
      .data_in(data_in), .data_out(data_out),
      .undergoing_command(undergoing_command), .send_me_next_byte(send_me_next_byte)
   );

   int         vecs = 0, miscmp = 0;
   int         done_cnt[N] = '{default:0};
   int         rv_cnt[N]   = '{default:0};
   logic [7:0] rq[$];
   int         order[$];
   logic [N-1:0] gnt_prev = '0;
   logic       en_seen = 1'b0;
   logic       rereq;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // one clock: wait for negedge, then play the clients and the monitors
   task automatic tick;
      @(negedge clk);
      if (client_rvalid != '0) begin
         if (rq.size() == 0) chk("rv_extra", client_rvalid, 0);
         else                chk("rdata", client_rdata, rq.pop_front());
      end
      for (int i = 0; i < N; i++) begin
         if (client_done[i])   begin done_cnt[i]++; client_req[i] = 1'b0; end
         if (client_rvalid[i]) rv_cnt[i]++;
         if (client_grant[i] && gnt_prev == '0) order.push_back(i);
      end
      gnt_prev = client_grant;
      if (output_enable || write_enable) en_seen = 1'b1;
   endtask

   // bridge model: accept the command, strobe nbytes every other cycle, go idle
   task automatic bridge(input int nbytes, input logic wr, input logic [N-1:0] oh);
      undergoing_command = 1'b1;
      tick;
      for (int b = 0; b < nbytes; b++) begin
         send_me_next_byte = 1'b1;
         #1;
         if (wr) begin
            chk("nxt_wr", client_next_byte, oh);
            chk("din", data_in, b & 255);
         end else begin
            chk("nxt_rd", client_next_byte, 0);
            rq.push_back(8'(cnt + RD_LAT));
         end
         if (b == 0) chk("en_busy", {output_enable, write_enable}, {~wr, wr});
         tick;
         send_me_next_byte = 1'b0;
         tick;
      end
      undergoing_command = 1'b0;
      #1;
      chk("retrig_en", {output_enable, write_enable}, 0);
      tick;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      client_req = '0;
      undergoing_command = 1'b0;
      send_me_next_byte = 1'b0;
      tick; tick;
      reset = 1'b0;
      for (int i = 0; i < N; i++) done_cnt[i] = 0;
      order.delete();
   endtask

   initial begin
      // reset state
      repeat (3) tick;
      #1;
      chk("rst_gnt",   client_grant, 0);
      chk("rst_en",    {output_enable, write_enable}, 0);
      chk("rst_sp",    start_pointer, 0);
      chk("rst_pulse", {client_done, client_rvalid, client_next_byte}, 0);
      chk("rst_din",   data_in, 0);
      reset = 1'b0;
      tick;

      // single read: client 1, block 0x12, one block
      client_we[1] = 1'b0;
      client_block_addr[BAW*1 +: BAW] = 16'h0012;
      client_num_blocks[5*1 +: 5] = 5'd1;
      client_req[1] = 1'b1;
      tick;
      chk("rd_gnt", client_grant, 4'b0010);
      chk("rd_sp",  start_pointer, 24'h000240);
      chk("rd_nob", number_of_blocks, 1);
      chk("rd_en",  {output_enable, write_enable}, 2'b10);
      bridge(32, 1'b0, 4'b0010);
      en_seen = 1'b0;
      repeat (14) tick;
      chk("rd_rvcnt",  rv_cnt[1], 32);
      chk("rd_done",   done_cnt[1], 1);
      chk("rd_drain",  rq.size(), 0);
      chk("rd_nogrant", client_grant, 0);
      chk("rd_noretrig", en_seen, 0);

      // single write: client 0, block 3, two blocks
      client_we[0] = 1'b1;
      client_block_addr[0 +: BAW] = 16'h0003;
      client_num_blocks[0 +: 5] = 5'd2;
      client_req[0] = 1'b1;
      tick;
      chk("wr_gnt", client_grant, 4'b0001);
      chk("wr_sp",  start_pointer, 24'h000060);
      chk("wr_nob", number_of_blocks, 2);
      chk("wr_en",  {output_enable, write_enable}, 2'b01);
      chk("wr_din0", data_in, 0);
      bridge(64, 1'b1, 4'b0001);
      repeat (5) tick;
      chk("wr_done",  done_cnt[0], 1);
      chk("wr_bytes", wbyte, 64);
      chk("wr_rvnone", rv_cnt[0], 0);

      // contention after reset: 0,2,3 together, 0 re-requests after its done
      do_reset;
      client_num_blocks = '0;
      en_seen = 1'b0;
      rereq = 1'b0;
      client_req = 4'b1101;
      for (int c = 0; c < 30; c++) begin
         tick;
         if (done_cnt[0] == 1 && !rereq) begin
            client_req[0] = 1'b1;
            rereq = 1'b1;
         end
      end
      chk("ct_n",  order.size(), 4);
      chk("ct_o0", order[0], 0);
      chk("ct_o1", order[1], 2);
      chk("ct_o2", order[2], 3);
      chk("ct_o3", order[3], 0);
      chk("ct_done0", done_cnt[0], 2);
      chk("ct_noen", en_seen, 0);

      // zero blocks: done two cycles after req, no bridge enables
      client_req[2] = 1'b1;
      tick;
      #1;
      chk("zb_gnt",   client_grant, 4'b0100);
      chk("zb_early", client_done, 0);
      tick;
      #1;
      chk("zb_done", client_done, 4'b0100);
      chk("zb_en",   {output_enable, write_enable}, 0);
      repeat (3) tick;

      // reset in the middle of a write from client 3
      client_we[3] = 1'b1;
      client_block_addr[BAW*3 +: BAW] = 16'h0100;
      client_num_blocks[5*3 +: 5] = 5'd1;
      client_req[3] = 1'b1;
      tick;
      chk("mr_gnt", client_grant, 4'b1000);
      chk("mr_sp",  start_pointer, 24'h002000);
      undergoing_command = 1'b1;
      tick;
      send_me_next_byte = 1'b1;
      #1;
      chk("mr_nxt", client_next_byte, 4'b1000);
      chk("mr_din", data_in, 8'hA3);
      tick;
      send_me_next_byte = 1'b0;
      tick;
      #1;
      chk("mr_we", write_enable, 1);
      reset = 1'b1;
      #1;
      chk("mr_gnt0", client_grant, 0);
      chk("mr_en0",  {output_enable, write_enable}, 0);
      chk("mr_out0", {start_pointer, number_of_blocks, data_in}, 0);
      undergoing_command = 1'b0;
      client_num_blocks[0 +: 5] = 5'd0;
      client_req = 4'b1001;
      tick;
      reset = 1'b0;
      tick;
      chk("mr_prio", client_grant, 4'b0001);
      repeat (10) tick;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
